// File: rtl/mc_cpu_pkg.sv
// Shared encodings for the multi-cycle MIPS core: opcodes, functs, ALU codes,
// FSM states, halt causes and the opcode/funct classifier.
package mc_cpu_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_SLTIU = 6'h0B;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] F_SLL  = 6'h00;
   localparam logic [5:0] F_SRL  = 6'h02;
   localparam logic [5:0] F_SRA  = 6'h03;
   localparam logic [5:0] F_SLLV = 6'h04;
   localparam logic [5:0] F_SRLV = 6'h06;
   localparam logic [5:0] F_SRAV = 6'h07;
   localparam logic [5:0] F_JR   = 6'h08;
   localparam logic [5:0] F_ADD  = 6'h20;
   localparam logic [5:0] F_ADDU = 6'h21;
   localparam logic [5:0] F_SUB  = 6'h22;
   localparam logic [5:0] F_SUBU = 6'h23;
   localparam logic [5:0] F_AND  = 6'h24;
   localparam logic [5:0] F_OR   = 6'h25;
   localparam logic [5:0] F_XOR  = 6'h26;
   localparam logic [5:0] F_NOR  = 6'h27;
   localparam logic [5:0] F_SLT  = 6'h2A;
   localparam logic [5:0] F_SLTU = 6'h2B;

   localparam logic [3:0] ALUC_ADD  = 4'h0;
   localparam logic [3:0] ALUC_SUB  = 4'h1;
   localparam logic [3:0] ALUC_AND  = 4'h2;
   localparam logic [3:0] ALUC_OR   = 4'h3;
   localparam logic [3:0] ALUC_XOR  = 4'h4;
   localparam logic [3:0] ALUC_NOR  = 4'h5;
   localparam logic [3:0] ALUC_SLT  = 4'h6;
   localparam logic [3:0] ALUC_SLTU = 4'h7;
   localparam logic [3:0] ALUC_SLL  = 4'h8;
   localparam logic [3:0] ALUC_SRL  = 4'h9;
   localparam logic [3:0] ALUC_SRA  = 4'hA;
   localparam logic [3:0] ALUC_LUI  = 4'hB;

   typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_e;
   typedef enum logic [1:0] {CAUSE_NONE, CAUSE_ILLEGAL, CAUSE_MISALIGN_DATA, CAUSE_MISALIGN_JR} cause_e;
   typedef enum logic [2:0] {K_ALU, K_LOAD, K_STORE, K_BEQ, K_BNE, K_J, K_JAL, K_JR} kind_e;

   typedef struct packed {
      logic       illegal;
      kind_e      kind;
      logic [3:0] aluc;
      logic       use_imm;  // ALU B operand is the extended immediate
      logic       zext;     // zero- rather than sign-extend the immediate
      logic       shamt_a;  // ALU A operand is the shamt field
      logic       dest_rt;  // write rt rather than rd
   } dec_t;

   function automatic dec_t decode(input logic [5:0] op, input logic [5:0] funct);
      dec_t d;
      d.illegal = 1'b0;
      d.kind    = K_ALU;
      d.aluc    = ALUC_ADD;
      d.use_imm = 1'b1;
      d.zext    = 1'b0;
      d.shamt_a = 1'b0;
      d.dest_rt = 1'b1;
      case (op)
         OP_RTYPE: begin
            d.use_imm = 1'b0;
            d.dest_rt = 1'b0;
            case (funct)
               F_ADD, F_ADDU: d.aluc = ALUC_ADD;
               F_SUB, F_SUBU: d.aluc = ALUC_SUB;
               F_AND:  d.aluc = ALUC_AND;
               F_OR:   d.aluc = ALUC_OR;
               F_XOR:  d.aluc = ALUC_XOR;
               F_NOR:  d.aluc = ALUC_NOR;
               F_SLT:  d.aluc = ALUC_SLT;
               F_SLTU: d.aluc = ALUC_SLTU;
               F_SLL:  begin d.aluc = ALUC_SLL; d.shamt_a = 1'b1; end
               F_SRL:  begin d.aluc = ALUC_SRL; d.shamt_a = 1'b1; end
               F_SRA:  begin d.aluc = ALUC_SRA; d.shamt_a = 1'b1; end
               F_SLLV: d.aluc = ALUC_SLL;
               F_SRLV: d.aluc = ALUC_SRL;
               F_SRAV: d.aluc = ALUC_SRA;
               F_JR:   d.kind = K_JR;
               default: d.illegal = 1'b1;
            endcase
         end
         OP_ADDI, OP_ADDIU: d.aluc = ALUC_ADD;
         OP_SLTI:  d.aluc = ALUC_SLT;
         OP_SLTIU: d.aluc = ALUC_SLTU;
         OP_ANDI:  begin d.aluc = ALUC_AND; d.zext = 1'b1; end
         OP_ORI:   begin d.aluc = ALUC_OR;  d.zext = 1'b1; end
         OP_XORI:  begin d.aluc = ALUC_XOR; d.zext = 1'b1; end
         OP_LUI:   d.aluc = ALUC_LUI;
         OP_LW:    d.kind = K_LOAD;
         OP_SW:    d.kind = K_STORE;
         OP_BEQ:   d.kind = K_BEQ;
         OP_BNE:   d.kind = K_BNE;
         OP_J:     d.kind = K_J;
         OP_JAL:   d.kind = K_JAL;
         default:  d.illegal = 1'b1;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/mc_alu.sv
// Combinational 32-bit ALU; shift amounts come from a_i[4:0], shifted value from b_i.
module mc_alu
   import mc_cpu_pkg::*;
(
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  logic [3:0]  aluc_i,
   output logic [31:0] r_o
);

   always_comb begin
      r_o = '0;
      case (aluc_i)
         ALUC_ADD:  r_o = a_i + b_i;
         ALUC_SUB:  r_o = a_i - b_i;
         ALUC_AND:  r_o = a_i & b_i;
         ALUC_OR:   r_o = a_i | b_i;
         ALUC_XOR:  r_o = a_i ^ b_i;
         ALUC_NOR:  r_o = ~(a_i | b_i);
         ALUC_SLT:  r_o = {31'b0, $signed(a_i) < $signed(b_i)};
         ALUC_SLTU: r_o = {31'b0, a_i < b_i};
         ALUC_SLL:  r_o = b_i << a_i[4:0];
         ALUC_SRL:  r_o = b_i >> a_i[4:0];
         ALUC_SRA:  r_o = $unsigned($signed(b_i) >>> a_i[4:0]);
         ALUC_LUI:  r_o = {b_i[15:0], 16'h0000};
         default:   r_o = '0;
      endcase
   end

endmodule

// File: rtl/mc_regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write port,
// r0 hard-wired to zero.
module mc_regfile (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [4:0]  ra1_i,
   input  logic [4:0]  ra2_i,
   output logic [31:0] rd1_o,
   output logic [31:0] rd2_o,
   input  logic        we_i,
   input  logic [4:0]  wa_i,
   input  logic [31:0] wd_i
);

   logic [31:0] regs_q [32];

   // NOTE: every entry is cleared on reset, so this array maps to flops rather than a RAM macro.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < 32; i++) regs_q[i] <= '0;
      end else if (we_i && (wa_i != 5'd0)) begin
         regs_q[wa_i] <= wd_i;
      end
   end

   assign rd1_o = (ra1_i == 5'd0) ? '0 : regs_q[ra1_i];
   assign rd2_o = (ra2_i == 5'd0) ? '0 : regs_q[ra2_i];

endmodule

// File: rtl/mc_cpu.sv
// Multi-cycle MIPS core: FETCH/DECODE/EXEC/MEM/WB sequencing with req/ready
// instruction and data memories, alignment checking and halt-with-cause.
module mc_cpu
   import mc_cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter bit          ALIGN_CHECK = 1'b1
) (
   input  logic        clk_in,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        imem_ready,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_ready,
   output logic [31:0] pc,
   output logic        retire,
   output logic        halted,
   output logic [1:0]  halt_cause
);

   state_e      state_q, state_d;
   cause_e      cause_q, cause_d;
   logic [31:0] pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d;
   logic [31:0] addr_q, addr_d, wb_q, wb_d;
   logic        run_q;

   dec_t        dec;
   logic [31:0] imm_ext, alu_a, alu_b, alu_r;
   logic [31:0] pc_plus4, br_target, jmp_target, rf_rd1, rf_rd2, rf_wd;
   logic [4:0]  rf_wa;
   logic        rf_we, data_bad;

   assign dec        = decode(ir_q[31:26], ir_q[5:0]);
   assign imm_ext    = dec.zext ? {16'h0000, ir_q[15:0]} : {{16{ir_q[15]}}, ir_q[15:0]};
   assign alu_a      = dec.shamt_a ? {27'b0, ir_q[10:6]} : a_q;
   assign alu_b      = dec.use_imm ? imm_ext : b_q;
   assign pc_plus4   = pc_q + 32'd4;
   assign br_target  = pc_plus4 + {imm_ext[29:0], 2'b00};
   assign jmp_target = {pc_q[31:28], ir_q[25:0], 2'b00};
   assign data_bad   = ALIGN_CHECK && (alu_r[1:0] != 2'b00);

   mc_alu u_alu (
      .a_i    (alu_a),
      .b_i    (alu_b),
      .aluc_i (dec.aluc),
      .r_o    (alu_r)
   );

   mc_regfile u_rf (
      .clk_i  (clk_in),
      .rst_ni (reset),
      .ra1_i  (ir_q[25:21]),
      .ra2_i  (ir_q[20:16]),
      .rd1_o  (rf_rd1),
      .rd2_o  (rf_rd2),
      .we_i   (rf_we),
      .wa_i   (rf_wa),
      .wd_i   (rf_wd)
   );

   // NOTE: every variable is given a default first so no path through the case infers a latch.
   always_comb begin
      state_d = state_q;
      cause_d = cause_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      a_d     = a_q;
      b_d     = b_q;
      addr_d  = addr_q;
      wb_d    = wb_q;
      rf_we   = 1'b0;
      rf_wa   = dec.dest_rt ? ir_q[20:16] : ir_q[15:11];
      rf_wd   = wb_q;
      retire  = 1'b0;
      case (state_q)
         S_FETCH: begin
            if (run_q && imem_ready) begin
               ir_d    = imem_rdata;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            a_d = rf_rd1;
            b_d = rf_rd2;
            if (dec.illegal) begin
               cause_d = CAUSE_ILLEGAL;
               state_d = S_HALT;
            end else begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            case (dec.kind)
               K_BEQ, K_BNE: begin
                  pc_d    = ((a_q == b_q) == (dec.kind == K_BEQ)) ? br_target : pc_plus4;
                  retire  = 1'b1;
                  state_d = S_FETCH;
               end
               K_J, K_JAL: begin
                  pc_d    = jmp_target;
                  rf_we   = (dec.kind == K_JAL);
                  rf_wa   = 5'd31;
                  rf_wd   = pc_plus4;
                  retire  = 1'b1;
                  state_d = S_FETCH;
               end
               K_JR: begin
                  if (ALIGN_CHECK && (a_q[1:0] != 2'b00)) begin
                     cause_d = CAUSE_MISALIGN_JR;
                     state_d = S_HALT;
                  end else begin
                     pc_d    = {a_q[31:2], 2'b00};
                     retire  = 1'b1;
                     state_d = S_FETCH;
                  end
               end
               K_LOAD, K_STORE: begin
                  if (data_bad) begin
                     cause_d = CAUSE_MISALIGN_DATA;
                     state_d = S_HALT;
                  end else begin
                     addr_d  = {alu_r[31:2], 2'b00};
                     state_d = S_MEM;
                  end
               end
               default: begin
                  wb_d    = alu_r;
                  state_d = S_WB;
               end
            endcase
         end
         S_MEM: begin
            if (dmem_ready) begin
               if (dec.kind == K_STORE) begin
                  pc_d    = pc_plus4;
                  retire  = 1'b1;
                  state_d = S_FETCH;
               end else begin
                  wb_d    = dmem_rdata;
                  state_d = S_WB;
               end
            end
         end
         S_WB: begin
            rf_we   = 1'b1;
            pc_d    = pc_plus4;
            retire  = 1'b1;
            state_d = S_FETCH;
         end
         S_HALT: state_d = S_HALT;
         default: state_d = S_FETCH;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         state_q <= S_FETCH;
         cause_q <= CAUSE_NONE;
         pc_q    <= RESET_PC;
         ir_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         addr_q  <= '0;
         wb_q    <= '0;
         run_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cause_q <= cause_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         a_q     <= a_d;
         b_q     <= b_d;
         addr_q  <= addr_d;
         wb_q    <= wb_d;
         run_q   <= 1'b1;
      end
   end

   // run_q keeps the first fetch off until one edge after reset release.
   assign imem_req   = run_q && (state_q == S_FETCH);
   assign imem_addr  = imem_req ? pc_q : '0;
   assign dmem_req   = (state_q == S_MEM);
   assign dmem_we    = dmem_req && (dec.kind == K_STORE);
   assign dmem_addr  = addr_q;
   assign dmem_wdata = b_q;
   assign pc         = pc_q;
   assign halted     = (state_q == S_HALT);
   assign halt_cause = cause_q;

endmodule

// File: tb/tb_mc_cpu.sv
// Directed bench for mc_cpu: word-array IMEM/DMEM models with programmable
// wait states, retire/transaction monitors and hand-computed expectations.
module tb_mc_cpu;

   localparam logic [31:0] BASE   = 32'h0000_3000;
   localparam logic [31:0] HALT_W = 32'hFC00_0000;

   logic        clk_in = 1'b0;
   logic        reset  = 1'b0;
   logic        imem_req, imem_ready, dmem_req, dmem_we, dmem_ready, retire, halted;
   logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata, pc;
   logic [1:0]  halt_cause;

   mc_cpu #(.RESET_PC(BASE), .ALIGN_CHECK(1'b1)) dut (
      .clk_in     (clk_in),
      .reset      (reset),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_rdata (imem_rdata),
      .imem_ready (imem_ready),
      .dmem_req   (dmem_req),
      .dmem_we    (dmem_we),
      .dmem_addr  (dmem_addr),
      .dmem_wdata (dmem_wdata),
      .dmem_rdata (dmem_rdata),
      .dmem_ready (dmem_ready),
      .pc         (pc),
      .retire     (retire),
      .halted     (halted),
      .halt_cause (halt_cause)
   );

   always #5 clk_in = ~clk_in;

   logic [31:0] imem [4096];
   logic [31:0] dmem [64];
   logic        tb_clr = 1'b1;
   int          i_wait = 0, d_wait = 0, i_cnt = 0, d_cnt = 0, cyc = 0;
   int          ret_n = 0, dtx_n = 0, dreq_cyc = 0, unstable = 0;
   int          ret_cyc [64];
   logic [31:0] ret_pc [64];
   int          dtx_len [64];
   logic [31:0] dtx_addr [64];
   logic [31:0] d_addr_prev = '0, d_wdata_prev = '0;
   int          checks = 0, errors = 0;

   assign imem_ready = imem_req && (i_cnt >= i_wait);
   assign imem_rdata = imem[imem_addr[13:2]];
   assign dmem_ready = dmem_req && (d_cnt >= d_wait);
   assign dmem_rdata = dmem[dmem_addr[7:2]];

   // Memory models: wait-state counters, store commit and data-transaction log.
   always @(posedge clk_in) begin
      cyc   <= cyc + 1;
      i_cnt <= (imem_req && !imem_ready) ? i_cnt + 1 : 0;
      d_cnt <= (dmem_req && !dmem_ready) ? d_cnt + 1 : 0;
      d_addr_prev  <= dmem_addr;
      d_wdata_prev <= dmem_wdata;
      if (tb_clr) begin
         dtx_n    <= 0;
         dreq_cyc <= 0;
         unstable <= 0;
         for (int i = 0; i < 64; i++) dmem[i] <= '0;
      end else begin
         if (dmem_req) begin
            dreq_cyc <= dreq_cyc + 1;
            if (d_cnt != 0 && (dmem_addr != d_addr_prev || dmem_wdata != d_wdata_prev))
               unstable <= unstable + 1;
         end
         if (dmem_ready) begin
            if (dtx_n < 64) begin
               dtx_len[dtx_n]  <= d_cnt + 1;
               dtx_addr[dtx_n] <= dmem_addr;
            end
            dtx_n <= dtx_n + 1;
            if (dmem_we) dmem[dmem_addr[7:2]] <= dmem_wdata;
         end
      end
   end

   always @(negedge clk_in) begin
      if (tb_clr) begin
         ret_n <= 0;
      end else if (reset && retire) begin
         if (ret_n < 64) begin
            ret_cyc[ret_n] <= cyc;
            ret_pc[ret_n]  <= pc;
         end
         ret_n <= ret_n + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic hold_reset();
      reset  = 1'b0;
      tb_clr = 1'b1;
      for (int i = 0; i < 4096; i++) imem[i] = HALT_W;
   endtask

   task automatic put(input logic [31:0] addr, input logic [31:0] word);
      imem[addr[13:2]] = word;
   endtask

   task automatic release_reset(input int iw, input int dw);
      i_wait = iw;
      d_wait = dw;
      repeat (2) @(negedge clk_in);
      tb_clr = 1'b0;
      reset  = 1'b1;
   endtask

   task automatic run_until(input int n_ret, input bit want_halt, input string tag);
      int k;
      bit done;
      k    = 0;
      done = 1'b0;
      while (!done && k < 400) begin
         @(negedge clk_in);
         k++;
         done = (ret_n >= n_ret) && (!want_halt || halted);
      end
      check({tag, "_timeout"}, {31'b0, done}, 32'd1);
   endtask

   initial begin
      int k;

      // Reset state, first fetch, then addi $1,$0,-5 / addu $2,$1,$1 / sw $2,8($0) at zero wait.
      hold_reset();
      put(BASE + 0, 32'h2001_FFFB);
      put(BASE + 4, 32'h0021_1021);
      put(BASE + 8, 32'hAC02_0008);
      i_wait = 0;
      d_wait = 0;
      repeat (2) @(negedge clk_in);
      check("rst_pc", pc, BASE);
      check("rst_imem_req", {31'b0, imem_req}, 32'd0);
      check("rst_dmem_req", {31'b0, dmem_req}, 32'd0);
      check("rst_retire", {31'b0, retire}, 32'd0);
      check("rst_halted", {31'b0, halted}, 32'd0);
      check("rst_cause", {30'b0, halt_cause}, 32'd0);
      tb_clr = 1'b0;
      reset  = 1'b1;
      #1 check("imem_req_before_edge", {31'b0, imem_req}, 32'd0);
      @(negedge clk_in);
      check("first_fetch_req", {31'b0, imem_req}, 32'd1);
      check("first_fetch_addr", imem_addr, BASE);
      run_until(3, 1'b1, "alu");
      check("alu_ret_n", ret_n, 32'd3);
      check("alu_ret_pc0", ret_pc[0], BASE);
      check("alu_cpi_addu", ret_cyc[1] - ret_cyc[0], 32'd4);
      check("alu_cpi_sw", ret_cyc[2] - ret_cyc[1], 32'd4);
      check("alu_store", dmem[2], 32'hFFFF_FFF6);
      check("illegal_cause", {30'b0, halt_cause}, 32'd1);
      check("illegal_pc", pc, BASE + 32'h0C);
      check("halt_imem_req", {31'b0, imem_req}, 32'd0);

      // sw/lw/sw with three data wait states.
      hold_reset();
      put(BASE + 0,  32'h2001_FFFB);
      put(BASE + 4,  32'h0021_1021);
      put(BASE + 8,  32'hAC02_0008);
      put(BASE + 12, 32'h8C03_0008);
      put(BASE + 16, 32'hAC03_000C);
      release_reset(0, 3);
      run_until(5, 1'b1, "ldst");
      check("ldst_ret_n", ret_n, 32'd5);
      check("ldst_tx_n", dtx_n, 32'd3);
      check("ldst_lw_len", dtx_len[1], 32'd4);
      check("ldst_lw_addr", dtx_addr[1], 32'd8);
      check("ldst_stable", unstable, 32'd0);
      check("ldst_sw_cycles", ret_cyc[2] - ret_cyc[1], 32'd7);
      check("ldst_lw_cycles", ret_cyc[3] - ret_cyc[2], 32'd8);
      check("ldst_lw_data", dmem[3], 32'hFFFF_FFF6);

      // j 0x20 / jal 0x28 at 0x20 / sw $31,16($0) / j 0x10 / beq $0,$0,-1 at 0x10.
      hold_reset();
      put(BASE, 32'h0800_0008);
      put(32'h20, 32'h0C00_000A);
      put(32'h28, 32'hAC1F_0010);
      put(32'h2C, 32'h0800_0004);
      put(32'h10, 32'h1000_FFFF);
      release_reset(0, 0);
      run_until(8, 1'b0, "br");
      check("br_jal_pc", ret_pc[1], 32'h20);
      check("br_ra", dmem[4], 32'h24);
      check("br_loop_pc", ret_pc[5], 32'h10);
      check("br_loop_cpi_a", ret_cyc[5] - ret_cyc[4], 32'd3);
      check("br_loop_cpi_b", ret_cyc[6] - ret_cyc[5], 32'd3);
      check("br_pc_now", pc, 32'h10);

      // lui / sra / slt / ori / nor / subu then stores, with two fetch wait states.
      hold_reset();
      put(BASE + 0,  32'h3C05_8000);
      put(BASE + 4,  32'h0005_3103);
      put(BASE + 8,  32'h00C0_382A);
      put(BASE + 12, 32'h3409_FFFF);
      put(BASE + 16, 32'h0000_5027);
      put(BASE + 20, 32'h00E9_5823);
      put(BASE + 24, 32'hAC06_0000);
      put(BASE + 28, 32'hAC07_0004);
      put(BASE + 32, 32'hAC09_0008);
      put(BASE + 36, 32'hAC0A_000C);
      put(BASE + 40, 32'hAC0B_0010);
      release_reset(2, 0);
      run_until(11, 1'b1, "mix");
      check("mix_cpi_iwait", ret_cyc[1] - ret_cyc[0], 32'd6);
      check("mix_sra", dmem[0], 32'hF800_0000);
      check("mix_slt", dmem[1], 32'h0000_0001);
      check("mix_ori", dmem[2], 32'h0000_FFFF);
      check("mix_nor", dmem[3], 32'hFFFF_FFFF);
      check("mix_subu", dmem[4], 32'hFFFF_0002);

      // addi $4,$0,7 then lw $4,2($0): misaligned data address.
      hold_reset();
      put(BASE + 0, 32'h2004_0007);
      put(BASE + 4, 32'h8C04_0002);
      release_reset(0, 0);
      run_until(1, 1'b1, "mis_lw");
      check("mis_lw_cause", {30'b0, halt_cause}, 32'd2);
      check("mis_lw_no_req", dreq_cyc, 32'd0);
      check("mis_lw_pc", pc, BASE + 32'h4);
      check("mis_lw_ret_n", ret_n, 32'd1);
      check("mis_lw_r4", dut.u_rf.regs_q[4], 32'd7);

      // addi $1,$0,0x22 then jr $1: misaligned jump target.
      hold_reset();
      put(BASE + 0, 32'h2001_0022);
      put(BASE + 4, 32'h0020_0008);
      release_reset(0, 0);
      run_until(1, 1'b1, "mis_jr");
      check("mis_jr_cause", {30'b0, halt_cause}, 32'd3);
      check("mis_jr_pc", pc, BASE + 32'h4);
      check("mis_jr_ret_n", ret_n, 32'd1);

      // addi $1,$0,5 / sw $1,0($0) with a long data wait, reset during the wait.
      hold_reset();
      put(BASE + 0, 32'h2001_0005);
      put(BASE + 4, 32'hAC01_0000);
      release_reset(0, 10);
      k = 0;
      while (!dmem_req && k < 100) begin
         @(negedge clk_in);
         k++;
      end
      check("rst_mid_req_seen", {31'b0, dmem_req}, 32'd1);
      @(negedge clk_in);
      #2 reset = 1'b0;
      #1 check("rst_mid_req_drop", {31'b0, dmem_req}, 32'd0);
      check("rst_mid_pc", pc, BASE);
      repeat (2) @(negedge clk_in);
      check("rst_mid_no_tx", dtx_n, 32'd0);
      check("rst_mid_no_store", dmem[0], 32'd0);
      check("rst_mid_r1", dut.u_rf.regs_q[1], 32'd0);
      reset = 1'b1;
      @(negedge clk_in);
      check("rst_mid_refetch_req", {31'b0, imem_req}, 32'd1);
      check("rst_mid_refetch_addr", imem_addr, BASE);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
